// File: rtl/aq_hpcp_of_ctrl.sv
// Overflow-side controller for the HPCP counter bank: sticky overflow status,
// interrupt mask, level interrupt and freeze-on-overflow global count enable.
module aq_hpcp_of_ctrl #(
  parameter int unsigned CNT_NUM = 16
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               cp0_hpcp_icg_en,
  input  logic               pad_yy_icg_scan_en,
  input  logic [CNT_NUM-1:0] cnt_of,
  input  logic               cp0_hpcp_glb_en,
  input  logic               cp0_hpcp_frz_en,
  input  logic               ofsts_wen,
  input  logic               ofmsk_wen,
  input  logic [63:0]        hpcp_wdata,
  output logic               hpcp_cnt_en,
  output logic               hpcp_int_vld,
  output logic [63:0]        hpcp_ofsts_value,
  output logic [63:0]        hpcp_ofmsk_value,
  output logic               hpcp_frozen
);

  localparam int unsigned DATA_W = 64;

  typedef enum logic {
    RUN    = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_NUM-1:0] ofsts;
  logic [CNT_NUM-1:0] ofmsk;
  logic [CNT_NUM-1:0] ofsts_next;
  logic [CNT_NUM-1:0] ofmsk_next;
  logic [CNT_NUM-1:0] wdata_cnt;
  logic               int_next;
  logic               hit;
  logic               glb_en_q;

  // Clock-gate control signals, matching the gated_clk_cell interface
  logic external_en;
  logic global_en;
  logic module_en;
  logic local_en;
  logic clk_en_bf_latch;
  logic clk_en_af_latch;
  logic gated_clk;

  // Write-data bits above the counter count carry no state
  logic unused_wdata_hi;

  assign wdata_cnt       = hpcp_wdata[CNT_NUM-1:0];
  assign unused_wdata_hi = ^hpcp_wdata[DATA_W-1:CNT_NUM];

  // Hardware set beats software write; software write beats hold
  assign ofsts_next = cnt_of | (ofsts_wen ? wdata_cnt : ofsts);
  assign ofmsk_next = ofmsk_wen ? wdata_cnt : ofmsk;
  assign hit        = |(cnt_of & ofmsk);
  assign int_next   = |(ofsts & ofmsk);

  // Clock runs whenever any register could change
  assign external_en     = 1'b0;
  assign global_en       = 1'b1;
  assign module_en       = cp0_hpcp_icg_en;
  assign local_en        = (|cnt_of) | ofsts_wen | ofmsk_wen | (state != RUN)
                         | (hpcp_int_vld != int_next);
  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Glitch-free enable latch, transparent while the clock is low
  always_latch begin
    if (!forever_cpuclk) begin
      clk_en_af_latch = clk_en_bf_latch | pad_yy_icg_scan_en;
    end
  end

  assign gated_clk = forever_cpuclk & clk_en_af_latch;

  // Sampled software global enable, on the free-running clock
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      glb_en_q <= 1'b0;
    end else begin
      glb_en_q <= cp0_hpcp_glb_en;
    end
  end

  // Sticky status, mask and registered interrupt
  always_ff @(posedge gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ofsts        <= '0;
      ofmsk        <= '0;
      hpcp_int_vld <= 1'b0;
    end else begin
      ofsts        <= ofsts_next;
      ofmsk        <= ofmsk_next;
      hpcp_int_vld <= int_next;
    end
  end

  // Freeze FSM state register
  always_ff @(posedge gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Freeze FSM next state: masked overflow freezes, clearing it unfreezes
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (cp0_hpcp_frz_en && hit) begin
          state_next = FROZEN;
        end
      end
      FROZEN: begin
        if (!cp0_hpcp_frz_en || ((ofsts_next & ofmsk_next) == '0)) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Freeze FSM outputs decoded from registered state
  always_comb begin
    hpcp_frozen = 1'b0;
    hpcp_cnt_en = 1'b0;
    if (state == FROZEN) begin
      hpcp_frozen = 1'b1;
    end
    hpcp_cnt_en = glb_en_q & ~hpcp_frozen;
  end

  assign hpcp_ofsts_value = DATA_W'(ofsts);
  assign hpcp_ofmsk_value = DATA_W'(ofmsk);

endmodule
